// File: rtl/lattice_analysis.sv
// Time-multiplexed LPC lattice analysis filter, one stage per clock.
// Double-buffered Q15 reflection coefficients, saturating Q15 datapath.
module lattice_analysis #(
  parameter int ORDER = 10,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] k,
  input  logic         kv,
  input  logic [W-1:0] x,
  input  logic         xv,
  output logic         xrdy,
  output logic [W-1:0] e,
  output logic         ev,
  output logic         coef_ok
);

  localparam int IW = $clog2(ORDER);
  localparam logic [IW-1:0] LAST = IW'(ORDER - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic signed [2*W:0] HALF = (2*W+1)'(2 ** (W - 2));
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  logic [1:0]            state;
  logic [IW-1:0]         widx;
  logic [IW-1:0]         sidx;
  logic                  swap_pend;
  logic signed [W-1:0]   shadow [ORDER];
  logic signed [W-1:0]   active [ORDER];
  logic signed [W-1:0]   bd     [ORDER];
  logic signed [W-1:0]   f;
  logic signed [W-1:0]   bcur;

  logic signed [W-1:0]   km;
  logic signed [W-1:0]   bm;
  logic signed [2*W-1:0] pf;
  logic signed [2*W-1:0] pb;
  logic signed [W:0]     fsum;
  logic signed [W:0]     bsum;
  logic signed [W-1:0]   fn;
  logic signed [W-1:0]   bn;
  logic                  accept;

  function automatic logic signed [W:0] rnd(
    input logic signed [2*W-1:0] p
  );
    logic signed [2*W:0] t;
    t = p;
    t = t + HALF;
    t = t >>> (W - 1);
    return t[W:0];
  endfunction

  function automatic logic signed [W-1:0] sat(
    input logic signed [W:0] v
  );
    if (v[W] != v[W-1])
      return v[W] ? SMIN : SMAX;
    return v[W-1:0];
  endfunction

  assign xrdy   = (state == IDLE) && coef_ok && !swap_pend;
  assign accept = xv && xrdy;

  // forward and backward branch each own one multiplier
  always_comb begin
    km   = active[sidx];
    bm   = bd[sidx];
    pf   = km * bm;
    pb   = km * f;
    fsum = $signed({f[W-1], f}) + rnd(pf);
    bsum = $signed({bm[W-1], bm}) + rnd(pb);
    fn   = sat(fsum);
    bn   = sat(bsum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      widx      <= '0;
      sidx      <= '0;
      swap_pend <= 1'b0;
      coef_ok   <= 1'b0;
      f         <= '0;
      bcur      <= '0;
      e         <= '0;
      ev        <= 1'b0;
      for (int i = 0; i < ORDER; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        bd[i]     <= '0;
      end
    end else begin
      ev <= 1'b0;

      if (kv) begin
        shadow[widx] <= k;
        widx <= (widx == LAST) ? '0 : widx + 1'b1;
      end

      // a set completing on a swap cycle must not be lost
      if (kv && widx == LAST)
        swap_pend <= 1'b1;
      else if (state == IDLE && swap_pend)
        swap_pend <= 1'b0;

      unique case (state)
        IDLE: begin
          if (accept) begin
            f     <= x;
            bcur  <= x;
            sidx  <= '0;
            state <= RUN;
          end else if (swap_pend) begin
            active  <= shadow;
            coef_ok <= 1'b1;
          end
        end
        RUN: begin
          f          <= fn;
          bcur       <= bn;
          bd[sidx]   <= bcur;
          if (sidx == LAST) begin
            e     <= fn;
            ev    <= 1'b1;
            state <= DONE;
          end else begin
            sidx <= sidx + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lattice_analysis.sv
// Directed bench for lattice_analysis (ORDER=10, W=16).
// Hand-computed residuals, latency, handshake and reset behaviour.
module tb_lattice_analysis;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] k;
  logic        kv;
  logic [15:0] x;
  logic        xv;
  logic        xrdy;
  logic [15:0] e;
  logic        ev;
  logic        coef_ok;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lattice_analysis #(.ORDER(10), .W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .k       (k),
    .kv      (kv),
    .x       (x),
    .xv      (xv),
    .xrdy    (xrdy),
    .e       (e),
    .ev      (ev),
    .coef_ok (coef_ok)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_e", e, 0);
    chk("rst_ev", ev, 0);
    chk("rst_xrdy", xrdy, 0);
    chk("rst_coef", coef_ok, 0);
  endtask

  task automatic load_set(input logic [15:0] k1);
    for (int i = 0; i < 10; i++) begin
      k  = (i == 0) ? k1 : 16'h0;
      kv = 1'b1;
      tick;
    end
    kv = 1'b0;
    tick;
    chk("load_coef", coef_ok, 1);
  endtask

  task automatic send(
    input logic [15:0] xs,
    input logic [15:0] exp,
    input string       tag,
    input bit          hold
  );
    int n;
    n = 0;
    while (!xrdy && n < 40) begin
      tick;
      n++;
    end
    chk({tag, "_rdy"}, xrdy, 1);
    x  = xs;
    xv = 1'b1;
    tick;
    if (!hold) xv = 1'b0;
    n = 1;
    while (!ev && n < 40) begin
      if (hold) chk({tag, "_hold"}, xrdy, 0);
      tick;
      n++;
    end
    if (hold) chk({tag, "_hold_done"}, xrdy, 0);
    xv = 1'b0;
    chk({tag, "_lat"}, n, 11);
    chk({tag, "_e"}, e, exp);
    tick;
    chk({tag, "_pulse"}, ev, 0);
  endtask

  initial begin
    rst = 1'b0;
    k   = '0;
    kv  = 1'b0;
    x   = '0;
    xv  = 1'b0;

    // xv before any coefficient set is ignored
    do_reset;
    x  = 16'h4321;
    xv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("early_rdy", xrdy, 0);
      chk("early_ev", ev, 0);
    end
    xv = 1'b0;

    // pass-through with all-zero coefficients
    load_set(16'h0000);
    chk("k0_rdy", xrdy, 1);
    send(16'h1234, 16'h1234, "k0_a", 1'b1);
    send(16'h8000, 16'h8000, "k0_b", 1'b0);

    // e = x + 0.5 x[n-1]
    do_reset;
    load_set(16'h4000);
    send(16'h1000, 16'h1000, "half_a", 1'b0);
    send(16'h1000, 16'h1800, "half_b", 1'b0);

    // positive and negative saturation
    do_reset;
    load_set(16'h7FFF);
    send(16'h7000, 16'h7000, "satp_a", 1'b0);
    send(16'h7000, 16'h7FFF, "satp_b", 1'b0);
    do_reset;
    load_set(16'h7FFF);
    send(16'h9000, 16'h9000, "satn_a", 1'b0);
    send(16'h9000, 16'h8000, "satn_b", 1'b0);

    // new set (k1=-0.5) loaded while a sample is in flight
    do_reset;
    load_set(16'h4000);
    send(16'h1000, 16'h1000, "sw_a", 1'b0);
    x  = 16'h1000;
    xv = 1'b1;
    tick;
    xv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      k  = (i == 0) ? 16'hC000 : 16'h0;
      kv = 1'b1;
      tick;
    end
    kv = 1'b0;
    chk("sw_b_ev", ev, 1);
    chk("sw_b_e", e, 16'h1800);
    tick;
    chk("sw_swap_rdy", xrdy, 0);
    chk("sw_swap_ev", ev, 0);
    tick;
    chk("sw_after_rdy", xrdy, 1);
    send(16'h1000, 16'h0800, "sw_c", 1'b0);

    // reset in the middle of RUN clears everything
    do_reset;
    load_set(16'h4000);
    x  = 16'h1000;
    xv = 1'b1;
    tick;
    xv = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_ev", ev, 0);
    chk("mid_coef", coef_ok, 0);
    chk("mid_rdy", xrdy, 0);
    chk("mid_e", e, 0);
    load_set(16'h4000);
    send(16'h1000, 16'h1000, "mid_x", 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
